booth_radix4_multiplier: RTL and testbench

Sequential, parametrised radix-4 Booth (bit-pair recoded) multiplier for the Mini SRC datapath's MUL instruction. It retires one recoded digit per clock, which replaces a single-cycle combinational recoder-plus-adder array. Results go to the HI/LO register pair. It adds a start/done handshake, a WIDTH parameter and a signed/unsigned mode.

---
 rtl/booth_radix4_multiplier_pkg.sv | 24 ++
 rtl/booth_radix4_multiplier_if.sv | 23 ++
 rtl/booth_radix4_multiplier_recoder.sv | 31 +++
 rtl/booth_radix4_multiplier.sv | 119 +++++++++++
 tb/tb_booth_radix4_multiplier.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/booth_radix4_multiplier_pkg.sv
// Shared types for the radix-4 Booth multiplier: state encoding, digit encoding and the
// digit-count helper.
package mul_pkg;

   typedef logic [1:0] state_t;

   localparam state_t StIdle = 2'd0;
   localparam state_t StRun  = 2'd1;
   localparam state_t StDone = 2'd2;

   typedef enum logic [2:0] {
      DigZero,
      DigPos1,
      DigPos2,
      DigNeg1,
      DigNeg2
   } digit_e;

   // Unsigned operands need one extra digit to consume the two zero-extension bits.
   function automatic int unsigned num_digits(input int unsigned width, input logic is_signed);
      return is_signed ? width / 2 : width / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_radix4_multiplier_if.sv
// Request/result bundle between the Mini SRC MUL issue logic and the Booth multiplier.
interface booth_radix4_multiplier_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product_hi;
   logic [WIDTH-1:0] product_lo;

   modport master (
      output start, is_signed, multiplicand, multiplier,
      input  busy, done, product_hi, product_lo
   );

   modport slave (
      input  start, is_signed, multiplicand, multiplier,
      output busy, done, product_hi, product_lo
   );
endinterface

// File: rtl/booth_radix4_multiplier_recoder.sv
// Radix-4 Booth recoder: maps the {q1, q0, q_prev} triplet to adder select lines.
module booth_digit_recoder
   import mul_pkg::*;
(
   input  logic [2:0] triplet_i,
   output logic       neg_o,
   output logic       two_o,
   output logic       zero_o
);

   digit_e digit;

   always_comb begin
      digit = DigZero;
      unique case (triplet_i)
         3'b000, 3'b111: digit = DigZero;
         3'b001, 3'b010: digit = DigPos1;
         3'b011:         digit = DigPos2;
         3'b100:         digit = DigNeg2;
         3'b101, 3'b110: digit = DigNeg1;
         default:        digit = DigZero;
      endcase
   end

   always_comb begin
      neg_o  = (digit == DigNeg1) || (digit == DigNeg2);
      two_o  = (digit == DigPos2) || (digit == DigNeg2);
      zero_o = (digit == DigZero);
   end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier: one recoded digit per clock, result to HI/LO.
// WIDTH must be even and at least 4.
module booth_radix4_multiplier
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic                      clk,
   input logic                      clr,
   booth_radix4_multiplier_if.slave bus
);

   localparam int unsigned AccW = WIDTH + 2;
   localparam int unsigned CntW = $clog2(WIDTH / 2 + 2);

   state_t           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [AccW-1:0]  a_q, a_d;
   logic [AccW-1:0]  q_q, q_d;
   logic [AccW-1:0]  m_q, m_d;
   logic             qprev_q, qprev_d;
   logic             signed_q, signed_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             neg, two, zero;
   logic [AccW-1:0]  pp, sum, a_sh, q_sh;
   logic [AccW-1:0]  m_ext, q_ext;

   booth_digit_recoder u_recoder (
      .triplet_i ({q_q[1:0], qprev_q}),
      .neg_o     (neg),
      .two_o     (two),
      .zero_o    (zero)
   );

   always_comb begin
      m_ext = bus.is_signed ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                            : {2'b00, bus.multiplicand};
      q_ext = bus.is_signed ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                            : {2'b00, bus.multiplier};
   end

   // Subtraction is invert plus carry-in on the single adder.
   always_comb begin
      pp   = zero ? '0 : (two ? {m_q[AccW-2:0], 1'b0} : m_q);
      sum  = a_q + (neg ? ~pp : pp) + {{(AccW-1){1'b0}}, neg};
      a_sh = {{2{sum[AccW-1]}}, sum[AccW-1:2]};
      q_sh = {sum[1:0], q_q[AccW-1:2]};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      q_d      = q_q;
      m_d      = m_q;
      qprev_d  = qprev_q;
      signed_d = signed_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         StRun: begin
            a_d     = a_sh;
            q_d     = q_sh;
            qprev_d = q_q[1];
            cnt_d   = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               state_d = StDone;
               // Product alignment in {A, Q} depends on how many digits were retired.
               {hi_d, lo_d} = signed_q ? {a_sh[WIDTH-1:0], q_sh[AccW-1:2]}
                                       : {a_sh[WIDTH-3:0], q_sh};
            end
         end
         default: begin
            state_d = StIdle;
            if (bus.start) begin
               state_d  = StRun;
               a_d      = '0;
               q_d      = q_ext;
               m_d      = m_ext;
               qprev_d  = 1'b0;
               signed_d = bus.is_signed;
               cnt_d    = CntW'(num_digits(WIDTH, bus.is_signed));
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         a_q      <= '0;
         q_q      <= '0;
         m_q      <= '0;
         qprev_q  <= 1'b0;
         signed_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         q_q      <= q_d;
         m_q      <= m_d;
         qprev_q  <= qprev_d;
         signed_q <= signed_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign bus.busy       = (state_q == StRun);
   assign bus.done       = (state_q == StDone);
   assign bus.product_hi = hi_q;
   assign bus.product_lo = lo_q;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench for booth_radix4_multiplier at WIDTH=32 and WIDTH=8 against an
// arithmetic reference multiply.
module tb_booth_radix4_multiplier;

   logic clk = 1'b0;
   logic clr;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   booth_radix4_multiplier_if #(.WIDTH(32)) bus32 ();
   booth_radix4_multiplier_if #(.WIDTH(8))  bus8 ();

   booth_radix4_multiplier #(.WIDTH(32)) u_dut32 (
      .clk (clk),
      .clr (clr),
      .bus (bus32.slave)
   );

   booth_radix4_multiplier #(.WIDTH(8)) u_dut8 (
      .clk (clk),
      .clr (clr),
      .bus (bus8.slave)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Extend both w-bit operands to 64 bits per mode, multiply, keep 2w bits.
   function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q,
                                           input bit sgn, input int w);
      logic [63:0] me, qe, p;
      for (int i = 0; i < 32; i++) begin
         me[i] = (i < w) ? m[i] : (sgn & m[w-1]);
         qe[i] = (i < w) ? q[i] : (sgn & q[w-1]);
      end
      for (int i = 32; i < 64; i++) begin
         me[i] = sgn & m[w-1];
         qe[i] = sgn & q[w-1];
      end
      p = me * qe;
      return p & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   task automatic get_out(input int w, output logic busy, output logic done,
                          output logic [63:0] prod);
      if (w == 32) begin
         busy = bus32.busy;
         done = bus32.done;
         prod = {bus32.product_hi, bus32.product_lo};
      end else begin
         busy = bus8.busy;
         done = bus8.done;
         prod = {48'd0, bus8.product_hi, bus8.product_lo};
      end
   endtask

   // Called at a negedge; returns at the negedge of cycle 1.
   task automatic start_op(input int w, input logic [31:0] m, input logic [31:0] q,
                           input bit sgn);
      if (w == 32) begin
         bus32.start        = 1'b1;
         bus32.multiplicand = m;
         bus32.multiplier   = q;
         bus32.is_signed    = sgn;
      end else begin
         bus8.start        = 1'b1;
         bus8.multiplicand = m[7:0];
         bus8.multiplier   = q[7:0];
         bus8.is_signed    = sgn;
      end
      @(negedge clk);
      bus32.start = 1'b0;
      bus8.start  = 1'b0;
   endtask

   task automatic wait_done(input int w, input int from, output int done_cyc,
                            output int busy_cnt);
      logic b, d;
      logic [63:0] p;
      int cyc;
      cyc      = from;
      done_cyc = -1;
      busy_cnt = 0;
      while (done_cyc < 0 && cyc < 64) begin
         get_out(w, b, d, p);
         if (b) busy_cnt++;
         if (d) done_cyc = cyc;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
   endtask

   task automatic run_check(input string tag, input int w, input logic [31:0] m,
                            input logic [31:0] q, input bit sgn);
      int dc, bc, n;
      logic b, d;
      logic [63:0] p;
      n = sgn ? w / 2 : w / 2 + 1;
      start_op(w, m, q, sgn);
      wait_done(w, 1, dc, bc);
      get_out(w, b, d, p);
      check($sformatf("%s_lat", tag), 64'(dc), 64'(n + 1));
      check($sformatf("%s_busy", tag), 64'(bc), 64'(n));
      check($sformatf("%s_prod", tag), p, ref_mul(m, q, sgn, w));
      @(negedge clk);
   endtask

   logic [31:0] c32[5];
   logic [31:0] c8[5];

   initial begin
      logic b, d;
      logic [63:0] p, first;
      int dc, bc, seen;
      logic [31:0] rm, rq;

      c32 = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
      c8  = '{32'h0, 32'h1, 32'hFF, 32'h7F, 32'h80};

      clr = 1'b1;
      bus32.start = 1'b0; bus32.is_signed = 1'b0;
      bus32.multiplicand = '0; bus32.multiplier = '0;
      bus8.start = 1'b0; bus8.is_signed = 1'b0;
      bus8.multiplicand = '0; bus8.multiplier = '0;
      repeat (2) @(negedge clk);

      get_out(32, b, d, p);
      check("rst_busy", 64'(b), 64'd0);
      check("rst_done", 64'(d), 64'd0);
      check("rst_prod", p, 64'd0);
      get_out(8, b, d, p);
      check("rst_prod8", p, 64'd0);
      clr = 1'b0;
      @(negedge clk);

      // 7 * -3 signed
      start_op(32, 32'd7, 32'hFFFF_FFFD, 1'b1);
      wait_done(32, 1, dc, bc);
      get_out(32, b, d, p);
      check("s7m3_lat", 64'(dc), 64'd17);
      check("s7m3_busy", 64'(bc), 64'd16);
      check("s7m3_prod", p, 64'hFFFF_FFFF_FFFF_FFEB);
      @(negedge clk);
      get_out(32, b, d, p);
      check("s7m3_pulse", 64'(d), 64'd0);
      check("s7m3_idle", 64'(b), 64'd0);
      check("s7m3_hold", p, 64'hFFFF_FFFF_FFFF_FFEB);

      run_check("smin", 32, 32'h8000_0000, 32'h8000_0000, 1'b1);
      get_out(32, b, d, p);
      check("smin_const", p, 64'h4000_0000_0000_0000);
      run_check("uff", 32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      get_out(32, b, d, p);
      check("uff_const", p, 64'hFFFF_FFFE_0000_0001);
      run_check("sff", 32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      get_out(32, b, d, p);
      check("sff_const", p, 64'd1);

      // start while busy is ignored; then back-to-back start in the done cycle
      first = ref_mul(32'h1234, 32'h5678, 1'b1, 32);
      start_op(32, 32'h1234, 32'h5678, 1'b1);
      repeat (4) @(negedge clk);
      start_op(32, 32'hDEAD, 32'hBEEF, 1'b0);
      wait_done(32, 6, dc, bc);
      get_out(32, b, d, p);
      check("busy_start_lat", 64'(dc), 64'd17);
      check("busy_start_prod", p, first);
      start_op(32, 32'h12345, 32'h0, 1'b1);
      get_out(32, b, d, p);
      check("b2b_busy", 64'(b), 64'd1);
      check("b2b_hold", p, first);
      wait_done(32, 1, dc, bc);
      get_out(32, b, d, p);
      check("b2b_lat", 64'(dc), 64'd17);
      check("b2b_prod", p, 64'd0);
      @(negedge clk);

      // asynchronous clear mid-run
      start_op(32, 32'h1111, 32'h2222, 1'b1);
      repeat (7) @(negedge clk);
      clr = 1'b1;
      #1;
      get_out(32, b, d, p);
      check("clr_busy", 64'(b), 64'd0);
      check("clr_done", 64'(d), 64'd0);
      check("clr_prod", p, 64'd0);
      @(negedge clk);
      clr  = 1'b0;
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         get_out(32, b, d, p);
         if (d) seen++;
      end
      check("clr_no_done", 64'(seen), 64'd0);
      run_check("after_clr", 32, 32'h0000_BEEF, 32'hFFFF_0001, 1'b1);

      // corner operand pairs, both modes, both widths
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            for (int s = 0; s < 2; s++) begin
               run_check($sformatf("c32_%0d_%0d_%0d", i, j, s), 32, c32[i], c32[j], s[0]);
               run_check($sformatf("c8_%0d_%0d_%0d", i, j, s), 8, c8[i], c8[j], s[0]);
            end
         end
      end

      for (int k = 0; k < 24; k++) begin
         rm = $urandom;
         rq = $urandom;
         run_check($sformatf("r32_%0d", k), 32, rm, rq, k[0]);
         run_check($sformatf("r8_%0d", k), 8, rm, rq, k[1]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
